regfile_mp: RTL

- Parametrised multi-port general-purpose register file for the pipelined MIPS datapath, replacing the fixed 2-read/1-write file.
- Provides NR read ports and two write ports (W0 = ALU writeback, W1 = load writeback).
- Provides same-cycle write-through bypass and a per-register pending scoreboard, so the decode stage can detect RAW hazards against in-flight producers.
- Register 0 is hardwired to zero.

---
 rtl/regfile_mp.sv | 125 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NR combinational read ports with write-through bypass,
// two write ports (W1 wins collisions) and a per-register pending scoreboard.
module regfile_mp #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] r_addr,
  output logic [NR*DW-1:0] r_data,
  output logic [NR-1:0]    r_pend,
  input  logic             w0_en,
  input  logic [AW-1:0]    w0_addr,
  input  logic [DW-1:0]    w0_data,
  input  logic             w1_en,
  input  logic [AW-1:0]    w1_addr,
  input  logic [DW-1:0]    w1_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [AW:0]      pend_cnt
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0]    regs_r [DEPTH];
  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_nxt_s;
  logic [AW:0]      pend_cnt_r;
  logic [AW:0]      pend_cnt_nxt_s;
  logic             w0_act_s;
  logic             w1_act_s;
  logic             iss_act_s;
  logic             inc_s;
  logic             dec0_s;
  logic             dec1_s;

  assign w0_act_s  = w0_en && (w0_addr != {AW{1'b0}});
  assign w1_act_s  = w1_en && (w1_addr != {AW{1'b0}});
  assign iss_act_s = iss_en && (iss_addr != {AW{1'b0}});

  // Register storage; W1 is applied last so it wins a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else begin
      if (w0_act_s) begin
        regs_r[w0_addr] <= w0_data;
      end
      if (w1_act_s) begin
        regs_r[w1_addr] <= w1_data;
      end
    end
  end

  // Scoreboard next state: a new issue beats a retiring write on the same register
  always_comb begin
    pend_nxt_s    = pend_r;
    pend_nxt_s[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (iss_act_s && (iss_addr == AW'(i))) begin
        pend_nxt_s[i] = 1'b1;
      end else if ((w0_act_s && (w0_addr == AW'(i))) ||
                   (w1_act_s && (w1_addr == AW'(i)))) begin
        pend_nxt_s[i] = 1'b0;
      end else begin
        pend_nxt_s[i] = pend_r[i];
      end
    end
  end

  // Incremental count update; each term only fires on a real 0->1 or 1->0 transition
  always_comb begin
    inc_s  = iss_act_s && !pend_r[iss_addr];
    dec0_s = w0_act_s && pend_r[w0_addr] &&
             !(iss_act_s && (iss_addr == w0_addr));
    dec1_s = w1_act_s && pend_r[w1_addr] &&
             !(iss_act_s && (iss_addr == w1_addr)) &&
             !(w0_act_s && (w0_addr == w1_addr));
    pend_cnt_nxt_s = pend_cnt_r + {{AW{1'b0}}, inc_s}
                                - {{AW{1'b0}}, dec0_s}
                                - {{AW{1'b0}}, dec1_s};
  end

  // Scoreboard and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r     <= {DEPTH{1'b0}};
      pend_cnt_r <= {(AW+1){1'b0}};
    end else begin
      pend_r     <= pend_nxt_s;
      pend_cnt_r <= pend_cnt_nxt_s;
    end
  end

  assign pend_cnt = pend_cnt_r;

  // Read ports with bypass; forced to zero while reset is held so bypassed
  // write data cannot leak out during reset
  always_comb begin
    r_data = {(NR*DW){1'b0}};
    r_pend = {NR{1'b0}};
    for (int k = 0; k < NR; k++) begin
      if (rst) begin
        r_data[k*DW +: DW] = {DW{1'b0}};
        r_pend[k]          = 1'b0;
      end else if (r_addr[k*AW +: AW] == {AW{1'b0}}) begin
        r_data[k*DW +: DW] = {DW{1'b0}};
        r_pend[k]          = 1'b0;
      end else if (w1_en && (w1_addr == r_addr[k*AW +: AW])) begin
        r_data[k*DW +: DW] = w1_data;
        r_pend[k]          = 1'b0;
      end else if (w0_en && (w0_addr == r_addr[k*AW +: AW])) begin
        r_data[k*DW +: DW] = w0_data;
        r_pend[k]          = 1'b0;
      end else begin
        r_data[k*DW +: DW] = regs_r[r_addr[k*AW +: AW]];
        r_pend[k]          = pend_r[r_addr[k*AW +: AW]];
      end
    end
  end

endmodule
